chan_scan_ctrl: RTL and testbench
=================================

Name: chan_scan_ctrl

Overview:
Round-robin channel scan sequencer driving the 4-to-16 decoder's select/enable inputs (sel -> d[3:0], en -> en).
- Walks 16 request lines and grants one channel at a time for a programmable dwell.
- Inserts a one-cycle enable-low gap between grants, so the decoded one-hot outputs never overlap or glitch between channels.

Parameters:
N_CH, 16, channel count; fixed to decoder width, not overridable in practice
SEL_W, 4, select width, log2(N_CH)
DWELL_W, 8, width of dwell length input

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
run  in  1  level; 1 = scanning permitted
req  in  16  per-channel request, sampled only when choosing next grant
dwell  in  DWELL_W  grant length in cycles; 0 treated as 1
done  in  1  early release from granted channel, sampled while en=1
sel  out  SEL_W  granted channel index, to decoder d
en  out  1  grant active, to decoder en
busy  out  1  state != IDLE
grant_pulse  out  1  high on first cycle of each grant only
wrap  out  1  1-cycle pulse when a new grant index <= previous grant index (pointer wrapped)

Behaviour:
- Reset, checked every edge: state=IDLE, sel=0, en=0, busy=0, grant_pulse=0, wrap=0, ptr=15, cnt=0. Reset mid-grant drops en on the next edge with no gap cycle.
- All outputs are registered. No combinational path from any input to any output.
- Pick function: first set bit of req at index (ptr+1+k) mod 16, k=0..15. ptr itself has lowest priority. Returns found flag plus index.
- States: IDLE, ACTIVE, GAP.
- IDLE, edge with run=1 and req!=0: sel=pick, ptr=pick, en=1, grant_pulse=1, cnt=max(dwell,1)-1, go ACTIVE.
  - Otherwise stay in IDLE with en=0.
  - Latency: req/run sampled at edge N; en=1 visible after edge N.
- ACTIVE: en=1 for exactly max(dwell,1) cycles (dwell sampled at grant start only).
  - Leave early if done=1 or run=0 is sampled: that cycle is the last en=1 cycle.
  - Leave when cnt==0; otherwise cnt decrements.
  - On exit: en=0, go GAP. sel holds its value.
  - req changes during ACTIVE are ignored; no preemption.
- GAP: exactly one cycle with en=0.
  - At the GAP edge, if run=1 and req!=0: start the next grant as in IDLE, go ACTIVE.
  - Else go IDLE.
  - Hence consecutive grants are separated by exactly one en=0 cycle.
- wrap: asserted together with grant_pulse when new index <= previous sel, including a re-grant of the same single channel. It is not asserted on the first grant after reset.
- Single requester: is re-granted repeatedly, with a GAP cycle between grants.
- done while en=0: ignored.
- dwell=255: en high for 255 cycles.

Optional Feature:
CHSCAN_GRANT_CNT_EN:
- Defined: adds output grant_cnt[15:0]. It increments on each grant_pulse, wraps 0xFFFF->0, and resets to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package chscan_pkg: N_CH, SEL_W, and the state enum {IDLE, ACTIVE, GAP}.
- One sub-module, rr_pick: combinational rotate-priority finder.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: found, idx[3:0].
  - Instantiated once.

Test Plan:
- Reset, then run=1, req=0x0001, dwell=3: en high 3 cycles with sel=0, then 1 gap cycle, then sel=0 again with wrap=1. grant_pulse fires on the first cycle of each grant.
- req=0x8421, dwell=2, run=1: sel sequence 0,5,10,15,0. Each grant lasts 2 cycles with a single en=0 gap between grants. wrap pulses on the return to 0.
- dwell=0, req=0x0006: each grant lasts 1 cycle, alternating sel 1,2,1 with a gap between each.
- dwell=10, req=0x0010, done pulsed on the 3rd en cycle: en drops after that cycle, the GAP follows, and the next grant starts.
- run dropped mid-grant (dwell=8, 4th cycle): en low next cycle, then GAP, then IDLE, busy=0. rst asserted mid-grant: all outputs return to reset values on the next edge.
- With CHSCAN_GRANT_CNT_EN and 70000 grants: grant_cnt == 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/chan_scan_ctrl_pkg.sv
// Shared constants and FSM state type for the channel scan sequencer.
package chscan_pkg;
  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;
endpackage

// File: rtl/chan_scan_ctrl_rr_pick.sv
// Rotating-priority finder: first set req bit after ptr, with ptr itself checked last.
module rr_pick
  import chscan_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand [N_CH];

  // cand[k] = (ptr+1+k) mod N_CH; the SEL_W-bit add supplies the modulo
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_cand
      assign cand[gi] = ptr + SEL_W'(gi + 1);
    end
  endgenerate

  // Scan from lowest to highest priority so the earliest candidate wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/chan_scan_ctrl.sv
// Round-robin channel scan sequencer feeding a 4-to-16 decoder (sel/en), one enable-low gap between grants.
// Optional grant counter output enabled by defining CHSCAN_GRANT_CNT_EN.
module chan_scan_ctrl
  import chscan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [N_CH-1:0]    req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               done,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               grant_pulse,
  output logic               wrap
`ifdef CHSCAN_GRANT_CNT_EN
  ,
  output logic [15:0]        grant_cnt
`endif
);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic               en_reg, en_next;
  logic               pulse_reg, pulse_next;
  logic               wrap_reg, wrap_next;
  logic               granted_reg, granted_next;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef CHSCAN_GRANT_CNT_EN
  logic [15:0] grant_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_reg <= '0;
    end else if (pulse_next) begin
      grant_cnt_reg <= grant_cnt_reg + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      ptr_reg     <= SEL_W'(N_CH - 1);
      cnt_reg     <= '0;
      en_reg      <= 1'b0;
      pulse_reg   <= 1'b0;
      wrap_reg    <= 1'b0;
      granted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      en_reg      <= en_next;
      pulse_reg   <= pulse_next;
      wrap_reg    <= wrap_next;
      granted_reg <= granted_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    en_next      = 1'b0;
    pulse_next   = 1'b0;
    wrap_next    = 1'b0;
    granted_next = granted_reg;
    case (state_reg)
      ACTIVE: begin
        // The cycle in which done/run=0/cnt==0 is seen is the last enabled one
        if (done || !run || (cnt_reg == '0)) begin
          state_next = GAP;
        end else begin
          en_next  = 1'b1;
          cnt_next = cnt_reg - DWELL_W'(1);
        end
      end
      default: begin
        // IDLE and GAP both launch a new grant when work is pending
        if (run && pick_found) begin
          state_next   = ACTIVE;
          sel_next     = pick_idx;
          ptr_next     = pick_idx;
          en_next      = 1'b1;
          pulse_next   = 1'b1;
          wrap_next    = granted_reg && (pick_idx <= sel_reg);
          cnt_next     = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          granted_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    sel         = sel_reg;
    en          = en_reg;
    busy        = (state_reg != IDLE);
    grant_pulse = pulse_reg;
    wrap        = wrap_reg;
`ifdef CHSCAN_GRANT_CNT_EN
    grant_cnt   = grant_cnt_reg;
`endif
  end

endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Scoreboard bench for chan_scan_ctrl: expected grants queued by stimulus, checked by a negedge monitor.
module tb_chan_scan_ctrl;
  import chscan_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic [N_CH-1:0]   req = '0;
  logic [7:0]        dwell = '0;
  logic              done = 1'b0;
  logic [SEL_W-1:0]  sel;
  logic              en;
  logic              busy;
  logic              grant_pulse;
  logic              wrap;
`ifdef CHSCAN_GRANT_CNT_EN
  logic [15:0]       grant_cnt;
`endif

  chan_scan_ctrl #(.DWELL_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .req         (req),
    .dwell       (dwell),
    .done        (done),
    .sel         (sel),
    .en          (en),
    .busy        (busy),
    .grant_pulse (grant_pulse),
    .wrap        (wrap)
`ifdef CHSCAN_GRANT_CNT_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int wrap;
    int gap;   // en-low cycles before this grant; -1 = don't care
    int len;   // en-high cycles; -1 = don't care
  } grant_t;

  grant_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int pulses_seen = 0;
  int pulses_since_rst = 0;
  bit active = 1'b0;
  int run_len = 0;
  int low_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int s, input int w, input int g, input int l);
    grant_t e;
    e.sel = s; e.wrap = w; e.gap = g; e.len = l;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation per grant_pulse, measures grant length and preceding gap
  initial begin
    grant_t cur;
    cur.sel = 0; cur.wrap = 0; cur.gap = -1; cur.len = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        low_cnt = 0;
        pulses_since_rst = 0;
      end else if (grant_pulse) begin
        pulses_seen++;
        pulses_since_rst++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: actual sel %0d, required no grant", sel);
        end else begin
          cur = exp_q.pop_front();
          check("grant_sel", int'(sel), cur.sel);
          check("grant_wrap", int'(wrap), cur.wrap);
          check("grant_en", int'(en), 1);
          if (cur.gap >= 0) check("grant_gap", low_cnt, cur.gap);
        end
        active = 1'b1;
        run_len = 1;
      end else if (en) begin
        if (active) run_len++;
      end else begin
        if (active) begin
          if (cur.len >= 0) check("grant_len", run_len, cur.len);
          active = 1'b0;
          low_cnt = 0;
        end
        low_cnt++;
      end
    end
  end

  task automatic wait_pulses(input int target);
    int t = 0;
    while (pulses_seen < target && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (pulses_seen < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pulses: actual %0d pulses, required %0d", pulses_seen, target);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || active || exp_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_en", int'(en), 0);
    check("idle_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    run = 1'b0;
    req = '0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, int'(sel), 0);
    check({tag, "_en"}, int'(en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pulse"}, int'(grant_pulse), 0);
    check({tag, "_wrap"}, int'(wrap), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single requester: re-granted with wrap after one gap cycle
    do_reset();
    base = pulses_seen;
    expect_grant(0, 0, -1, 3);
    expect_grant(0, 1, 1, 3);
    dwell = 8'd3; req = 16'h0001; run = 1'b1;
    wait_pulses(base + 2);
    req = '0;
    wait_idle();

    // Four requesters walked in order, wrapping back to 0
    do_reset();
    base = pulses_seen;
    expect_grant(0, 0, -1, 2);
    expect_grant(5, 0, 1, 2);
    expect_grant(10, 0, 1, 2);
    expect_grant(15, 0, 1, 2);
    expect_grant(0, 1, 1, 2);
    dwell = 8'd2; req = 16'h8421; run = 1'b1;
    wait_pulses(base + 5);
    req = '0;
    wait_idle();

    // dwell=0 behaves as 1
    do_reset();
    base = pulses_seen;
    expect_grant(1, 0, -1, 1);
    expect_grant(2, 0, 1, 1);
    expect_grant(1, 1, 1, 1);
    dwell = 8'd0; req = 16'h0006; run = 1'b1;
    wait_pulses(base + 3);
    req = '0;
    wait_idle();

    // Early release with done on the 3rd enabled cycle
    do_reset();
    base = pulses_seen;
    expect_grant(4, 0, -1, 3);
    expect_grant(4, 1, 1, 10);
    dwell = 8'd10; req = 16'h0010; run = 1'b1;
    wait_pulses(base + 1);
    repeat (2) @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk);
    #1 done = 1'b0;
    wait_pulses(base + 2);
    req = '0;
    wait_idle();

    // run dropped on the 4th enabled cycle
    do_reset();
    base = pulses_seen;
    expect_grant(4, 0, -1, 4);
    dwell = 8'd8; req = 16'h0010; run = 1'b1;
    wait_pulses(base + 1);
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    wait_idle();

    // Reset mid-grant, then first grant after reset must not wrap
    expect_grant(4, 1, -1, -1);
    run = 1'b1;
    wait_pulses(base + 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    expect_grant(4, 0, -1, 8);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_pulses(base + 3);
    req = '0;
    wait_idle();

    // Maximum dwell
    do_reset();
    base = pulses_seen;
    expect_grant(7, 0, -1, 255);
    dwell = 8'd255; req = 16'h0080; run = 1'b1;
    wait_pulses(base + 1);
    req = '0;
    wait_idle();
`ifdef CHSCAN_GRANT_CNT_EN
    check("grant_cnt", int'(grant_cnt), pulses_since_rst);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
